// File: rtl/ps2_pkg.sv
// Shared constants, scan-code tables and sequencer state type for the ASCII to PS/2 path.
// Build option ASCII_TO_PS2_SHIFT_EN adds the left-shift wrapper states for uppercase.
package ps2_pkg;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] SC_ENTER     = 8'h5A;
  localparam logic [7:0] SC_SPACE     = 8'h29;
  localparam logic [7:0] SC_LSHIFT    = 8'h12;
  localparam logic [7:0] LCD_ENTER    = 8'hC0;

  // Set-2 make codes, 'a' first; uppercase letters reuse this table.
  localparam logic [7:0] LC_TBL [0:25] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  localparam logic [7:0] DIG_TBL [0:9] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAKE,
    ST_BRK_PFX,
    ST_BRK,
    ST_GAP
`ifdef ASCII_TO_PS2_SHIFT_EN
    ,
    ST_SH_MAKE,
    ST_SH_PFX,
    ST_SH_BRK
`endif
  } seq_state_e;

endpackage

// File: rtl/ascii_to_ps2_seq_if.sv
// Character-in / scan-code-out bundle for ascii_to_ps2_seq, plus status and a state tap.
interface ascii_to_ps2_seq_if;

  // Both sides: a beat transfers on a rising clk where valid & ready; the source
  // holds data stable and valid high until then, and ready may depend on nothing upstream.
  logic [7:0]             in_data;
  logic                   in_rs;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             code_out;
  logic                   code_valid;
  logic                   code_ready;
  logic                   unknown;
  logic                   busy;
  ps2_pkg::seq_state_e    dbg_state;

  modport master (
    output in_data, in_rs, in_valid, code_ready,
    input  in_ready, code_out, code_valid, unknown, busy, dbg_state
  );

  modport slave (
    input  in_data, in_rs, in_valid, code_ready,
    output in_ready, code_out, code_valid, unknown, busy, dbg_state
  );

endinterface

// File: rtl/ascii_scancode_lut.sv
// Combinational LCD character to PS/2 Set-2 make-code lookup.
// With ASCII_TO_PS2_SHIFT_EN, uppercase letters are known and flagged as needing shift.
module ascii_scancode_lut
  import ps2_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       rs_i,
  output logic [7:0] make_o,
  output logic       known_o,
  output logic       needs_shift_o
);

  always_comb begin
    make_o        = 8'h00;
    known_o       = 1'b0;
    needs_shift_o = 1'b0;
    if (rs_i) begin
      if (data_i >= 8'h61 && data_i <= 8'h7A) begin
        // Letter index is the low five bits minus one for both cases.
        make_o  = LC_TBL[data_i[4:0] - 5'd1];
        known_o = 1'b1;
      end else if (data_i >= 8'h30 && data_i <= 8'h39) begin
        make_o  = DIG_TBL[data_i[3:0]];
        known_o = 1'b1;
      end else if (data_i == 8'h20) begin
        make_o  = SC_SPACE;
        known_o = 1'b1;
      end
`ifdef ASCII_TO_PS2_SHIFT_EN
      else if (data_i >= 8'h41 && data_i <= 8'h5A) begin
        make_o        = LC_TBL[data_i[4:0] - 5'd1];
        known_o       = 1'b1;
        needs_shift_o = 1'b1;
      end
`endif
    end else if (data_i == LCD_ENTER) begin
      make_o  = SC_ENTER;
      known_o = 1'b1;
    end
  end

endmodule

// File: rtl/ascii_to_ps2_seq.sv
// Turns one LCD character into the make / F0 / make keystroke byte stream, then idles GAP_CYCLES.
// ASCII_TO_PS2_SHIFT_EN wraps uppercase letters in left-shift make and break.
module ascii_to_ps2_seq
  import ps2_pkg::*;
#(
  parameter int GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  ascii_to_ps2_seq_if.slave bus
);

  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  seq_state_e    state_q;
  logic [7:0]    code_q;
  logic          valid_q;
  logic          unknown_q;
  logic [7:0]    make_q;
  logic [GW-1:0] gap_q;
`ifdef ASCII_TO_PS2_SHIFT_EN
  logic          shift_q;
`endif

  logic [7:0] lut_make;
  logic       lut_known;
  logic       lut_shift;
  logic       accept_d;
  logic       xfer_d;
  logic       char_ok_d;
  logic       last_byte_d;

  ascii_scancode_lut u_lut (
    .data_i        (bus.in_data),
    .rs_i          (bus.in_rs),
    .make_o        (lut_make),
    .known_o       (lut_known),
    .needs_shift_o (lut_shift)
  );

  assign accept_d = bus.in_valid & (state_q == ST_IDLE);
  assign xfer_d   = valid_q & bus.code_ready;

`ifdef ASCII_TO_PS2_SHIFT_EN
  assign char_ok_d = lut_known;
`else
  // Without the shift states a shifted character cannot be sequenced.
  assign char_ok_d = lut_known & ~lut_shift;
`endif

  always_comb begin
    last_byte_d = 1'b0;
    if (xfer_d) begin
      if (state_q == ST_BRK) last_byte_d = 1'b1;
`ifdef ASCII_TO_PS2_SHIFT_EN
      if (state_q == ST_BRK && shift_q) last_byte_d = 1'b0;
      if (state_q == ST_SH_BRK)         last_byte_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      code_q    <= 8'h00;
      valid_q   <= 1'b0;
      unknown_q <= 1'b0;
      make_q    <= 8'h00;
      gap_q     <= '0;
`ifdef ASCII_TO_PS2_SHIFT_EN
      shift_q   <= 1'b0;
`endif
    end else begin
      unknown_q <= 1'b0;
      if (last_byte_d) begin
        valid_q <= 1'b0;
        code_q  <= 8'h00;
        if (GAP_CYCLES > 0) begin
          state_q <= ST_GAP;
          gap_q   <= GAP_LOAD;
        end else begin
          state_q <= ST_IDLE;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept_d) begin
              if (char_ok_d) begin
                make_q  <= lut_make;
                valid_q <= 1'b1;
`ifdef ASCII_TO_PS2_SHIFT_EN
                shift_q <= lut_shift;
                if (lut_shift) begin
                  state_q <= ST_SH_MAKE;
                  code_q  <= SC_LSHIFT;
                end else
`endif
                begin
                  state_q <= ST_MAKE;
                  code_q  <= lut_make;
                end
              end else begin
                unknown_q <= 1'b1;
              end
            end
          end
          ST_MAKE: if (xfer_d) begin
            state_q <= ST_BRK_PFX;
            code_q  <= BREAK_PREFIX;
          end
          ST_BRK_PFX: if (xfer_d) begin
            state_q <= ST_BRK;
            code_q  <= make_q;
          end
          ST_GAP: begin
            if (gap_q <= GW'(1)) begin
              state_q <= ST_IDLE;
              gap_q   <= '0;
            end else begin
              gap_q <= gap_q - GW'(1);
            end
          end
`ifdef ASCII_TO_PS2_SHIFT_EN
          ST_SH_MAKE: if (xfer_d) begin
            state_q <= ST_MAKE;
            code_q  <= make_q;
          end
          // Reaching here means BRK transferred with shift pending.
          ST_BRK: if (xfer_d) begin
            state_q <= ST_SH_PFX;
            code_q  <= BREAK_PREFIX;
          end
          ST_SH_PFX: if (xfer_d) begin
            state_q <= ST_SH_BRK;
            code_q  <= SC_LSHIFT;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;
  assign bus.unknown    = unknown_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_ascii_to_ps2_seq.sv
// Bench for ascii_to_ps2_seq: directed keystrokes, backpressure, reset abort, then random characters.
// Honours ASCII_TO_PS2_SHIFT_EN for the uppercase expectations.
module tb_ascii_to_ps2_seq;

  localparam int G = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   rdy_mode = 0;

  ascii_to_ps2_seq_if bus ();

  ascii_to_ps2_seq #(.GAP_CYCLES(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];       // {last_byte, byte}
  logic [7:0] exp_unk_q[$];
  logic [7:0] plain_map[int]; // key = rs*256 + data
  logic [7:0] shift_map[int];
  bit         gap_active = 0;
  int         gap_deadline = 0;

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic build_model();
    string lc;
    string dg;
    logic [7:0] lc_codes [0:25];
    logic [7:0] dg_codes [0:9];
    lc = "abcdefghijklmnopqrstuvwxyz";
    dg = "0123456789";
    lc_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    dg_codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 26; i++) begin
      plain_map[256 + int'(lc[i])] = lc_codes[i];
`ifdef ASCII_TO_PS2_SHIFT_EN
      shift_map[256 + int'(lc[i]) - 32] = lc_codes[i];
`endif
    end
    for (int i = 0; i < 10; i++) plain_map[256 + int'(dg[i])] = dg_codes[i];
    plain_map[256 + 32] = 8'h29;
    plain_map[8'hC0]    = 8'h5A;
  endtask

  // Push the keystroke a keyboard would send; returns whether any bytes are expected.
  function automatic bit model_push(input logic [7:0] d, input logic rs);
    int key;
    logic [7:0] mk;
    key = (rs ? 256 : 0) + int'(d);
    if (plain_map.exists(key)) begin
      mk = plain_map[key];
      exp_q.push_back({1'b0, mk});
      exp_q.push_back({1'b0, 8'hF0});
      exp_q.push_back({1'b1, mk});
      return 1'b1;
    end else if (shift_map.exists(key)) begin
      mk = shift_map[key];
      exp_q.push_back({1'b0, 8'h12});
      exp_q.push_back({1'b0, mk});
      exp_q.push_back({1'b0, 8'hF0});
      exp_q.push_back({1'b0, mk});
      exp_q.push_back({1'b0, 8'hF0});
      exp_q.push_back({1'b1, 8'h12});
      return 1'b1;
    end
    exp_unk_q.push_back(d);
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d, input logic rs);
    bit got;
    bit known;
    got = 0;
    known = 0;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_rs    = rs;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bus.in_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check("accept_wait", got, 32'(got), 32'd1);
    if (got) known = model_push(d, rs);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_rs    = 1'($urandom);
    if (got && known) check("first_byte_latency", bus.code_valid == 1'b1, 32'(bus.code_valid), 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_unk_q.size() == 0 && !gap_active && bus.in_ready && !bus.code_valid) begin
        done = 1;
        break;
      end
    end
    check("drain_timeout", done, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_f0(output bit found);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (bus.code_valid && bus.code_out == 8'hF0) begin
        found = 1;
        break;
      end
    end
    check("reach_break_prefix", found, 32'(bus.code_out), 32'hF0);
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_mode == 1) bus.code_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    bit         prev_stall;
    logic [7:0] prev_code;
    logic [8:0] e;
    prev_stall = 0;
    prev_code  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        gap_active = 0;
      end else begin
        if (!bus.code_valid) check("code_out_zero_when_idle", bus.code_out == 8'h00, 32'(bus.code_out), 32'd0);
        check("busy_vs_ready", bus.busy == !bus.in_ready, 32'(bus.busy), 32'(!bus.in_ready));
        if (prev_stall) begin
          check("stall_valid_held", bus.code_valid == 1'b1, 32'(bus.code_valid), 32'd1);
          check("stall_data_held", bus.code_out == prev_code, 32'(bus.code_out), 32'(prev_code));
        end
        if (gap_active) begin
          if (cyc < gap_deadline) begin
            check("gap_ready_low", bus.in_ready == 1'b0, 32'(bus.in_ready), 32'd0);
          end else if (cyc == gap_deadline) begin
            check("gap_ready_rise", bus.in_ready == 1'b1, 32'(bus.in_ready), 32'd1);
            gap_active = 0;
          end
        end
        if (bus.unknown) begin
          check("unknown_expected", exp_unk_q.size() > 0, 32'd1, 32'(exp_unk_q.size()));
          if (exp_unk_q.size() > 0) void'(exp_unk_q.pop_front());
          check("unknown_ready_high", bus.in_ready == 1'b1, 32'(bus.in_ready), 32'd1);
          check("unknown_no_valid", bus.code_valid == 1'b0, 32'(bus.code_valid), 32'd0);
        end
        if (bus.code_valid && bus.code_ready) begin
          if (exp_q.size() == 0) begin
            check("byte_unexpected", 1'b0, 32'(bus.code_out), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("byte_value", bus.code_out == e[7:0], 32'(bus.code_out), 32'(e[7:0]));
            if (e[8]) begin
              gap_active   = 1;
              gap_deadline = cyc + 1 + G;
            end
          end
        end
        prev_stall = bus.code_valid && !bus.code_ready;
        prev_code  = bus.code_out;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    bit found;
    logic [7:0] d;
    logic       rs;
    build_model();
    bus.in_data    = 8'h00;
    bus.in_rs      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.code_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready == 1'b1, 32'(bus.in_ready), 32'd1);
    check("rst_code_valid", bus.code_valid == 1'b0, 32'(bus.code_valid), 32'd0);
    check("rst_code_out", bus.code_out == 8'h00, 32'(bus.code_out), 32'd0);
    check("rst_unknown", bus.unknown == 1'b0, 32'(bus.unknown), 32'd0);
    check("rst_busy", bus.busy == 1'b0, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    // 'a' with code_ready high: three bytes on consecutive cycles
    send(8'h61, 1'b1);
    @(negedge clk);
    check("a_byte2_valid", bus.code_valid == 1'b1, 32'(bus.code_valid), 32'd1);
    @(negedge clk);
    check("a_byte3_valid", bus.code_valid == 1'b1, 32'(bus.code_valid), 32'd1);
    @(negedge clk);
    check("a_after_valid", bus.code_valid == 1'b0, 32'(bus.code_valid), 32'd0);
    drain();

    send(8'hC0, 1'b0);
    drain();

    // '5' held off for five cycles on the F0 byte
    send(8'h35, 1'b1);
    wait_f0(found);
    if (found) begin
      bus.code_ready = 1'b0;
      repeat (5) begin
        @(posedge clk);
        #2;
        check("bp_hold_valid", bus.code_valid == 1'b1, 32'(bus.code_valid), 32'd1);
        check("bp_hold_f0", bus.code_out == 8'hF0, 32'(bus.code_out), 32'hF0);
      end
      bus.code_ready = 1'b1;
    end
    drain();

    send(8'h7E, 1'b1);
    send(8'hC1, 1'b0);
    drain();

    // reset while the break prefix is on the bus
    send(8'h71, 1'b1);
    wait_f0(found);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", bus.code_valid == 1'b0, 32'(bus.code_valid), 32'd0);
    check("async_rst_code", bus.code_out == 8'h00, 32'(bus.code_out), 32'd0);
    check("async_rst_busy", bus.busy == 1'b0, 32'(bus.busy), 32'd0);
    exp_q.delete();
    exp_unk_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.in_ready == 1'b1, 32'(bus.in_ready), 32'd1);
    send(8'h7A, 1'b1);
    drain();

    send(8'h41, 1'b1);
    drain();

    // random characters with random backpressure
    rdy_mode = 1;
    repeat (60) begin
      case ($urandom_range(0, 5))
        0: begin d = 8'($urandom_range(8'h61, 8'h7A)); rs = 1'b1; end
        1: begin d = 8'($urandom_range(8'h30, 8'h39)); rs = 1'b1; end
        2: begin d = 8'h20; rs = 1'b1; end
        3: begin d = 8'hC0; rs = 1'b0; end
        4: begin d = 8'($urandom_range(8'h41, 8'h5A)); rs = 1'b1; end
        default: begin d = 8'($urandom); rs = 1'($urandom); end
      endcase
      send(d, rs);
    end
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #2 bus.code_ready = 1'b1;

    check("exp_q_empty", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    check("exp_unk_q_empty", exp_unk_q.size() == 0, 32'(exp_unk_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ascii_to_ps2_seq.md
Name: ascii_to_ps2_seq

Overview:
- Inverse of the keyboard decode path: takes an LCD-style character (8-bit data plus RS flag) and emits the PS/2 Set-2 scan-code byte stream a keyboard would send for one keystroke: make code, then 0xF0, then the make code again.
- Sits between the character source (test injector or LCD-echo loopback) and the PS/2 byte-level transmitter.
- Byte-level valid/ready on both sides; enforces a configurable idle gap between keystrokes.

Parameters:
- GAP_CYCLES, 4, idle cycles after the final byte of a keystroke before a new character is accepted; 0 is legal.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  character code (ASCII, or 0xC0 with in_rs=0 for Enter)
- in_rs  in  1  1 = printable character, 0 = command (Enter)
- in_valid  in  1  character offered
- in_ready  out  1  block can accept a character
- code_out  out  8  scan-code byte; 0x00 when code_valid=0
- code_valid  out  1  code_out valid
- code_ready  in  1  downstream accepts the byte
- unknown  out  1  one-cycle pulse: accepted character has no mapping
- busy  out  1  a sequence or gap is in progress

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: in_ready=1, code_valid=0, code_out=0x00, unknown=0, busy=0, state=IDLE, gap counter=0.
  - Reset asserted mid-sequence abandons the sequence immediately; code_valid drops asynchronously.
- Accept rule:
  - Transfer occurs when in_valid & in_ready in cycle N.
  - in_data/in_rs are registered.
  - in_ready is high only in IDLE.
- Mapping, with in_rs=1:
  - a–z 0x61–0x7A → 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - 0–9 0x30–0x39 → 45 16 1E 26 25 2E 36 3D 3E 46.
  - space 0x20 → 29.
- Mapping, with in_rs=0: data 0xC0 → 5A.
- Any other combination (including rs=0 with other data, and 0xF0) is unknown.
- Known character:
  - State goes MAKE at N+1; code_valid=1 at N+1 with the make code.
- Unknown character:
  - unknown=1 for cycle N+1 only.
  - No code_valid; return to IDLE with in_ready=1 at N+1, no gap.
- States and transitions:
  - IDLE → MAKE → BRK_PFX → BRK → GAP → IDLE.
  - Each byte state holds code_out and code_valid stable until code_valid & code_ready.
  - The next byte is presented in the cycle after the transfer; there are no bubbles other than this.
  - MAKE drives the make code, BRK_PFX drives 0xF0, BRK drives the make code again.
- Backpressure: code_ready may be low indefinitely; the output must not change while code_valid=1 and code_ready=0.
- Gap:
  - The final byte transfers in cycle T.
  - GAP_CYCLES>0: counter loads GAP_CYCLES, decrements each cycle, and the block enters IDLE when it reaches 0, so in_ready rises at T+1+GAP_CYCLES.
  - GAP_CYCLES=0: go straight to IDLE, in_ready=1 at T+1.
  - Counter width is max(1, clog2(GAP_CYCLES+1)).
- busy=1 in every state except IDLE.
- in_valid while in_ready=0 is ignored; upstream holds the character.

Optional Feature:
- Macro: ASCII_TO_PS2_SHIFT_EN.
- Defined:
  - Uppercase A–Z 0x41–0x5A with rs=1 map to the lowercase make code wrapped in left shift.
  - Sequence: 12, mk, F0, mk, F0, 12, using extra states SH_MAKE before MAKE and SH_PFX, SH_BRK after BRK.
  - Lowercase and the other codes are unchanged.
- Not defined: 0x41–0x5A are unknown and the shift states do not exist.

Decomposition:
- ps2_pkg:
  - Constants BREAK_PREFIX=8'hF0, SC_ENTER=8'h5A, SC_SPACE=8'h29, SC_LSHIFT=8'h12, LCD_ENTER=8'hC0.
  - State enum for the sequencer.
- Sub-module ascii_scancode_lut:
  - Combinational; inputs data, rs.
  - Outputs make[7:0], known, needs_shift.
- The sequencer, handshake logic and gap counter live in the top module.

Test Plan:
- 'a' (0x61, rs=1), code_ready=1, GAP=4 → bytes 1C, F0, 1C on consecutive cycles N+1..N+3; in_ready=0 until T+5, then 1.
- Enter (0xC0, rs=0) → 5A, F0, 5A.
- Backpressure: '5' (0x35) with code_ready low for 5 cycles during the F0 byte → code_out=F0 and code_valid=1 held stable; output 2E, F0, 2E.
- Unknown: 0x7E rs=1, then 0xC1 rs=0 → unknown pulses 1 cycle each; code_valid never asserts; in_ready=1 the cycle after each.
- Reset during BRK_PFX → code_valid=0 and code_out=00 without waiting for a clock edge; after release, 'z' (0x7A) → 1A, F0, 1A.
- 'A' (0x41):
  - With ASCII_TO_PS2_SHIFT_EN → 12, 1C, F0, 1C, F0, 12.
  - Without it → unknown pulse, no bytes.
